// File: rtl/pool_pkg.sv
// Shared types and default sizing for the pooling window reader.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int REG_NUM_DEF    = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int WIN_SIZE_DEF   = 4;
  localparam int WIN_LOG2       = $clog2(WIN_SIZE_DEF);

endpackage

// File: rtl/pool_reduce.sv
// Window accumulator: signed max, or signed sum with arithmetic-shift average
// when built with POOL_AVG_EN.
module pool_reduce #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  acc_en,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] result
);

`ifdef POOL_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  // Sum mode needs log2(window) guard bits so the total cannot overflow.
  localparam int ACC_W = DATA_WIDTH + (AVG ? WIN_LOG2 : 0);

  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] acc_p2;

  assign din_ext = ACC_W'($signed(din));

`ifdef POOL_AVG_EN
  function automatic logic [DATA_WIDTH-1:0] avg_trunc(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> WIN_LOG2;
    return shifted[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
    end else if (load) begin
      acc_p2 <= din_ext;
    end else if (acc_en) begin
      if (mode)
        acc_p2 <= acc_p2 + din_ext;
      else if (din_ext > acc_p2)
        acc_p2 <= din_ext;
    end
  end

  assign result = mode ? avg_trunc(acc_p2) : acc_p2[DATA_WIDTH-1:0];
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p2 <= '0;
    end else if (load) begin
      acc_p2 <= din_ext;
    end else if (acc_en && (din_ext > acc_p2)) begin
      acc_p2 <= din_ext;
    end
  end

  assign result = acc_p2[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/pool_window_reader.sv
// Walks a wrapping window of register addresses and reduces the returned data
// to one value on a valid/ready output. POOL_AVG_EN adds avg_sel (average mode).
module pool_window_reader
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WIN_SIZE   = WIN_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef POOL_AVG_EN
  input  logic                  avg_sel,
`endif
  input  logic [ADDR_WIDTH-1:0] base_adrs,
  output logic [ADDR_WIDTH-1:0] rd_adrs,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  pool_valid,
  input  logic                  pool_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int WLOG2 = $clog2(WIN_SIZE);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(WIN_SIZE - 1);

  state_t                state_p0;
  logic [ADDR_WIDTH-1:0] base_p0;
  logic [ADDR_WIDTH-1:0] cnt_p0;
  logic                  mode_p0;
  logic                  vld_p1;
  logic                  load_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= IDLE;
      base_p0    <= '0;
      cnt_p0     <= '0;
      mode_p0    <= 1'b0;
      vld_p1     <= 1'b0;
      load_p1    <= 1'b0;
      pool_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Stage p1: the register file answers one cycle after each READ address.
      vld_p1  <= (state_p0 == READ);
      load_p1 <= (state_p0 == READ) && (cnt_p0 == '0);
      done    <= 1'b0;
      case (state_p0)
        IDLE: begin
          if (start) begin
            base_p0  <= base_adrs;
            cnt_p0   <= '0;
`ifdef POOL_AVG_EN
            mode_p0  <= avg_sel;
`else
            mode_p0  <= 1'b0;
`endif
            state_p0 <= READ;
          end
        end
        READ: begin
          cnt_p0 <= cnt_p0 + 1'b1;
          if (cnt_p0 == CNT_LAST)
            state_p0 <= DRAIN;
        end
        DRAIN: begin
          state_p0   <= OUT;
          pool_valid <= 1'b1;
        end
        OUT: begin
          if (pool_ready) begin
            state_p0   <= IDLE;
            pool_valid <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign rd_adrs = (state_p0 == READ)
                   ? ADDR_WIDTH'((32'(base_p0) + 32'(cnt_p0)) % REG_NUM)
                   : '0;
  assign busy    = (state_p0 != IDLE);

  pool_reduce #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WLOG2)
  ) u_reduce (
    .clk    (clk),
    .rst    (rst),
    .load   (load_p1),
    .acc_en (vld_p1),
    .mode   (mode_p0),
    .din    (rd_data),
    .result (pool_out)
  );

endmodule

// File: tb/tb_pool_window_reader.sv
// Directed bench for pool_window_reader with a one-cycle-latency register file model.
module tb_pool_window_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        avg_sel;
  logic [3:0]  base_adrs;
  logic [3:0]  rd_adrs;
  logic [15:0] rd_data;
  logic [15:0] pool_out;
  logic        pool_valid;
  logic        pool_ready;
  logic        busy;
  logic        done;

  logic [15:0] regf [16];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= regf[rd_adrs];

  pool_window_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef POOL_AVG_EN
    .avg_sel    (avg_sel),
`endif
    .base_adrs  (base_adrs),
    .rd_adrs    (rd_adrs),
    .rd_data    (rd_data),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [3:0]       base;
    logic [3:0][15:0] d;
    logic             mode;
    logic [15:0]      exp;
  } vec_t;

  vec_t vt [12];
  int   nv;

  function automatic vec_t mk(input logic [3:0] b, input logic [15:0] a0, a1, a2, a3,
                              input logic m, input logic [15:0] e);
    vec_t v;
    v.base = b;
    v.d[0] = a0; v.d[1] = a1; v.d[2] = a2; v.d[3] = a3;
    v.mode = m;
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_regs(input logic [3:0] b, input logic [3:0][15:0] d);
    for (int i = 0; i < 4; i++) regf[4'(b + 4'(i))] = d[i];
  endtask

  // One full window with pool_ready high; cycle n is the cycle after edge n.
  task automatic run_window(input vec_t v, input string tag);
    load_regs(v.base, v.d);
    @(negedge clk);
    start = 1'b1; base_adrs = v.base; avg_sel = v.mode;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s rd_adrs c%0d", tag, i + 1), 32'(rd_adrs), 32'(4'(v.base + 4'(i))));
      if (i == 0) chk({tag, " busy c1"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk({tag, " valid low c5"}, 32'(pool_valid), 32'd0);
    @(negedge clk);
    chk({tag, " valid c6"}, 32'(pool_valid), 32'd1);
    chk({tag, " pool_out c6"}, 32'(pool_out), 32'(v.exp));
    chk({tag, " done low c6"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, " done c7"}, 32'(done), 32'd1);
    chk({tag, " valid drop c7"}, 32'(pool_valid), 32'd0);
    chk({tag, " busy c7"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " done clear c8"}, 32'(done), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_adrs"}, 32'(rd_adrs), 32'd0);
    chk({tag, " pool_out"}, 32'(pool_out), 32'd0);
    chk({tag, " pool_valid"}, 32'(pool_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; avg_sel = 1'b0; base_adrs = '0; pool_ready = 1'b1;
    for (int i = 0; i < 16; i++) regf[i] = 16'h0000;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    nv = 0;
    vt[nv++] = mk(4'd0,  16'd3,    16'd9,    16'hFFFE, 16'd5,    1'b0, 16'd9);
    vt[nv++] = mk(4'd14, 16'hFFF9, 16'hFFFD, 16'hFFF7, 16'hFFFC, 1'b0, 16'hFFFD);
    vt[nv++] = mk(4'd5,  16'h8000, 16'h7FFF, 16'd0,    16'd1,    1'b0, 16'h7FFF);
    vt[nv++] = mk(4'd3,  16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 1'b0, 16'hFFFF);
    vt[nv++] = mk(4'd9,  16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, 1'b0, 16'hFFFB);
    vt[nv++] = mk(4'd13, 16'd1,    16'd2,    16'd3,    16'h7FFE, 1'b0, 16'h7FFE);
`ifdef POOL_AVG_EN
    vt[nv++] = mk(4'd0,  16'd4,    16'd6,    16'hFFFD, 16'd1,    1'b1, 16'd2);
    vt[nv++] = mk(4'd2,  16'hFFFF, 16'd0,    16'd0,    16'd0,    1'b1, 16'hFFFF);
    vt[nv++] = mk(4'd10, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF);
    vt[nv++] = mk(4'd15, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h8000);
    vt[nv++] = mk(4'd4,  16'd4,    16'd6,    16'hFFFD, 16'd1,    1'b0, 16'd6);
`endif
    for (int i = 0; i < nv; i++) run_window(vt[i], $sformatf("vec%0d", i));

    // Backpressure with start pulses while busy.
    load_regs(4'd4, {16'd40, 16'd30, 16'd20, 16'd10});
    pool_ready = 1'b0;
    @(negedge clk);
    start = 1'b1; base_adrs = 4'd4;
    @(negedge clk);                       // cycle 1
    start = 1'b0;
    @(negedge clk);                       // cycle 2
    start = 1'b1; base_adrs = 4'd0;
    @(negedge clk);                       // cycle 3
    start = 1'b0;
    chk("bp rd_adrs c3", 32'(rd_adrs), 32'd6);
    repeat (3) @(negedge clk);            // cycle 6
    start = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      chk($sformatf("bp valid c%0d", c), 32'(pool_valid), 32'd1);
      chk($sformatf("bp out c%0d", c), 32'(pool_out), 32'd40);
      chk($sformatf("bp done c%0d", c), 32'(done), 32'd0);
      @(negedge clk);
      start = 1'b0;
    end
    chk("bp valid c11", 32'(pool_valid), 32'd1);
    pool_ready = 1'b1;
    @(negedge clk);
    chk("bp done", 32'(done), 32'd1);
    chk("bp valid drop", 32'(pool_valid), 32'd0);
    @(negedge clk);
    chk("bp no restart", 32'(busy), 32'd0);

    // Reset in the middle of READ, then a clean window.
    load_regs(4'd0, {16'd100, 16'd100, 16'd100, 16'd100});
    @(negedge clk);
    start = 1'b1; base_adrs = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);            // cycle 3
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_window(mk(4'd8, 16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3, 1'b0, 16'hFFF3), "postrst");

    // Back-to-back: start in the done cycle.
    load_regs(4'd1, {16'd4, 16'd3, 16'd2, 16'd1});
    load_regs(4'd6, {16'd2, 16'd7, 16'hFFFF, 16'd5});
    @(negedge clk);
    start = 1'b1; base_adrs = 4'd1;
    @(negedge clk);                       // cycle 1
    start = 1'b0;
    repeat (5) @(negedge clk);            // cycle 6
    chk("b2b first out", 32'(pool_out), 32'd4);
    @(negedge clk);                       // cycle 7
    chk("b2b done", 32'(done), 32'd1);
    start = 1'b1; base_adrs = 4'd6;
    @(negedge clk);                       // second window cycle 1
    start = 1'b0;
    chk("b2b rd_adrs", 32'(rd_adrs), 32'd6);
    chk("b2b busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    chk("b2b valid", 32'(pool_valid), 32'd1);
    chk("b2b second out", 32'(pool_out), 32'd7);
    @(negedge clk);
    chk("b2b done2", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
